return_address_stack: RTL and testbench
=======================================

Name: return_address_stack

Overview:
- Return address stack (RAS) for the fetch stage. It sits directly downstream of the branch predictor.
- It consumes the predictor's call/return classification of each fetched control-flow instruction and supplies a predicted return target back to fetch.
- It keeps a speculative circular stack of return addresses.
- A recovery FIFO of index snapshots, one per in-flight predicted branch, lets the stack pointer rewind when a misprediction flushes the front end.

Parameters:
- DEPTH, 8, number of return-address entries; power of two, at least 2.
- RECOVERY_DEPTH, 8, number of in-flight predicted-branch snapshots held; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low (reset asserted when rst==0).
- push  in  1  fetched instruction predicted as a call; push new_addr.
- pop  in  1  fetched instruction predicted as a return; pop top entry.
- new_addr  in  32  return address to push (call PC + instruction length).
- addr  out  32  current top-of-stack prediction.
- valid  out  1  stack holds at least one entry; addr is meaningful.
- branch_fetched  in  1  a predicted branch was fetched; snapshot stack state.
- branch_retired  in  1  oldest in-flight predicted branch resolved correctly; release oldest snapshot.
- early_branch_flush  in  1  front-end flush on misprediction; restore oldest snapshot.

Behaviour:
- State: stack memory (DEPTH x 32, not reset), read_index (log2 DEPTH bits), count (0..DEPTH), recovery FIFO (RECOVERY_DEPTH x {read_index, count}) with its own head/tail/occupancy.
- Reset (rst==0 at edge): read_index=0, count=0, FIFO empty. Outputs: valid=0; addr is don't-care while valid=0.
- addr is a combinational read of stack[read_index]. A push becomes visible on addr the cycle after it is accepted.
- Push only: read_index <= read_index+1 (mod DEPTH); stack[read_index+1] <= new_addr; count <= min(count+1, DEPTH). Push when full overwrites the oldest entry.
- Pop only: read_index <= read_index-1 (mod DEPTH); count <= count-1. Pop with count==0 is a no-op: read_index and count unchanged.
- Push and pop in the same cycle (coroutine return-call): stack[read_index] <= new_addr. read_index and count unchanged. If count==0, behave as push only.
- valid = (count != 0).
- branch_fetched: enqueue {read_index, count} as they are before any same-cycle push/pop. If the FIFO is full, the request is dropped and a sticky lost flag is set.
- branch_retired: dequeue the oldest snapshot. Ignored if the FIFO is empty.
- branch_fetched and branch_retired in the same cycle: both apply. On a full FIFO the dequeue frees space first, so nothing is lost. On an empty FIFO only the enqueue occurs.
- early_branch_flush:
  - If the FIFO is non-empty: read_index and count <= oldest snapshot.
  - If the FIFO is empty: state unchanged.
  - In both cases the FIFO is cleared and lost is cleared.
  - Flush has priority: any same-cycle push, pop, branch_fetched or branch_retired is ignored.
- lost flag: while set, flush restores only the oldest snapshot. The flag is also cleared when the FIFO drains to empty.
- Single-cycle throughput for all operations; no stalls, no backpressure.
- Reset mid-operation: reset dominates every input in that cycle.

Optional Feature:
- Macro: RAS_RECOVERY_EN.
- Defined: recovery FIFO and flush rewind as described above.
- Undefined:
  - No FIFO is built; branch_fetched, branch_retired and early_branch_flush are ignored.
  - The stack is purely speculative and corrupts on mispredicted paths.
  - Push/pop/valid/addr behaviour is identical to the defined case.

Test Plan:
- Reset, then push 0x100, 0x200, 0x300 on consecutive cycles -> addr=0x300 and valid=1 the next cycle. Three pops -> addr 0x200, then 0x100, then valid=0.
- DEPTH=8: push 0x10..0x90 (9 values) -> count stays 8 and addr=0x90. Pop 8 times -> last addr seen is 0x20 and valid=0; a ninth pop leaves read_index unchanged.
- Push 0x100, then push+pop with new_addr=0x500 in the same cycle -> addr=0x500, count=1. One pop -> valid=0.
- Push 0xA0, branch_fetched, push 0xB0, push 0xC0, early_branch_flush -> addr=0xA0, count=1, FIFO empty (RAS_RECOVERY_EN defined).
- Fill the FIFO with 8 branch_fetched pulses, then a 9th branch_fetched together with branch_retired -> no loss, occupancy 8. Flush with the same-cycle pop -> pop ignored, state equals the second snapshot.
- RAS_RECOVERY_EN undefined: push 0xA0, branch_fetched, push 0xB0, flush -> addr stays 0xB0.

Source files
------------

// File: rtl/return_address_stack_if.sv
// return_address_stack_if: call/return and branch-tracking signals between fetch and the RAS
interface return_address_stack_if;
    logic        push;
    logic        pop;
    logic [31:0] new_addr;
    logic [31:0] addr;
    logic        valid;
    logic        branch_fetched;
    logic        branch_retired;
    logic        early_branch_flush;
    modport master (
        output push, pop, new_addr, branch_fetched, branch_retired, early_branch_flush,
        input  addr, valid
    );
    modport slave (
        input  push, pop, new_addr, branch_fetched, branch_retired, early_branch_flush,
        output addr, valid
    );
endinterface

// File: rtl/return_address_stack.sv
// return_address_stack: circular return-address stack; RAS_RECOVERY_EN adds a snapshot FIFO for flush rewind
module return_address_stack #(
    parameter int DEPTH          = 8,
    parameter int RECOVERY_DEPTH = 8
) (
    input logic                   clk,
    input logic                   rst,
    return_address_stack_if.slave io
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   stack_q [DEPTH];
    logic [IW-1:0] read_index_q, read_index_d, wr_idx, rs_idx;
    logic [CW-1:0] count_q, count_d, rs_cnt;
    logic          flush, restore, do_push, do_pop, wr_en;

`ifdef RAS_RECOVERY_EN
    localparam int RW = $clog2(RECOVERY_DEPTH);
    logic [IW-1:0] snap_idx_q [RECOVERY_DEPTH];
    logic [CW-1:0] snap_cnt_q [RECOVERY_DEPTH];
    logic [RW-1:0] head_q, head_d, tail_q, tail_d;
    logic [RW:0]   occ_q, occ_d;
    logic          lost_q, lost_d, enq, deq;
    always_comb begin
        flush   = io.early_branch_flush;
        restore = flush & (occ_q != '0);
        rs_idx  = snap_idx_q[head_q];
        rs_cnt  = snap_cnt_q[head_q];
        deq     = ~flush & io.branch_retired & (occ_q != '0);
        enq     = ~flush & io.branch_fetched & ((occ_q != (RW+1)'(RECOVERY_DEPTH)) | deq);
        head_d  = flush ? '0 : head_q + RW'(deq);
        tail_d  = flush ? '0 : tail_q + RW'(enq);
        occ_d   = flush ? '0 : occ_q + (RW+1)'(enq) - (RW+1)'(deq);
        lost_d  = ~flush & (occ_d != '0) & (lost_q | (io.branch_fetched & ~enq));
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            lost_q <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            lost_q <= lost_d;
        end
    end
    // Snapshot storage holds state as it was before any same-cycle push/pop.
    always_ff @(posedge clk) begin
        if (rst && enq) begin
            snap_idx_q[tail_q] <= read_index_q;
            snap_cnt_q[tail_q] <= count_q;
        end
    end
`else
    logic unused_recovery;
    assign unused_recovery = ^{io.branch_fetched, io.branch_retired, io.early_branch_flush};
    assign flush   = 1'b0;
    assign restore = 1'b0;
    assign rs_idx  = '0;
    assign rs_cnt  = '0;
`endif

    always_comb begin
        do_push      = ~flush & io.push & (~io.pop | (count_q == '0));
        do_pop       = ~flush & io.pop & ~io.push & (count_q != '0);
        wr_en        = ~flush & io.push;
        wr_idx       = do_push ? read_index_q + 1'b1 : read_index_q;
        read_index_d = restore ? rs_idx : do_push ? read_index_q + 1'b1 : do_pop ? read_index_q - 1'b1 : read_index_q;
        count_d      = restore ? rs_cnt : (do_push && count_q != CW'(DEPTH)) ? count_q + 1'b1 : do_pop ? count_q - 1'b1 : count_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            read_index_q <= '0;
            count_q      <= '0;
        end else begin
            read_index_q <= read_index_d;
            count_q      <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && wr_en) stack_q[wr_idx] <= io.new_addr;
    end

    assign io.addr  = stack_q[read_index_q];
    assign io.valid = (count_q != '0);
endmodule

// File: tb/tb_return_address_stack.sv
// tb_return_address_stack: directed and random checks of the RAS against a circular-array reference model
module tb_return_address_stack;
    localparam int D  = 8;
    localparam int RD = 8;

    typedef struct {int ri; int cnt;} snap_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    return_address_stack_if io();
    return_address_stack #(.DEPTH(D), .RECOVERY_DEPTH(RD)) dut (.clk(clk), .rst(rst), .io(io));

    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_mem [D];
    int          m_ri  = 0;
    int          m_cnt = 0;
    snap_t       m_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_valid"}, {31'b0, io.valid}, {31'b0, m_cnt != 0});
        chk({tag, "_count"}, 32'(dut.count_q), 32'(m_cnt));
        if (m_cnt != 0) chk({tag, "_addr"}, io.addr, m_mem[m_ri]);
`ifdef RAS_RECOVERY_EN
        chk({tag, "_occ"}, 32'(dut.occ_q), 32'(m_q.size()));
`endif
    endtask

    task automatic cyc(input bit ph, input bit po, input logic [31:0] a,
                       input bit bf = 0, input bit br = 0, input bit fl = 0, input bit rn = 1);
        snap_t s;
        rst = rn;
        io.push = ph; io.pop = po; io.new_addr = a;
        io.branch_fetched = bf; io.branch_retired = br; io.early_branch_flush = fl;
        if (!rn) begin
            m_ri = 0; m_cnt = 0; m_q.delete();
        end else begin
            bit skip = 0;
`ifdef RAS_RECOVERY_EN
            if (fl) begin
                if (m_q.size() > 0) begin m_ri = m_q[0].ri; m_cnt = m_q[0].cnt; end
                m_q.delete();
                skip = 1;
            end else begin
                s.ri = m_ri; s.cnt = m_cnt;
                if (br && m_q.size() > 0) void'(m_q.pop_front());
                if (bf && m_q.size() < RD) m_q.push_back(s);
            end
`endif
            if (!skip) begin
                if (ph && (!po || m_cnt == 0)) begin
                    m_ri = (m_ri + 1) % D;
                    m_mem[m_ri] = a;
                    if (m_cnt < D) m_cnt++;
                end else if (ph && po) begin
                    m_mem[m_ri] = a;
                end else if (po && m_cnt > 0) begin
                    m_ri = (m_ri + D - 1) % D;
                    m_cnt--;
                end
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        io.push = 0; io.pop = 0; io.new_addr = 0;
        io.branch_fetched = 0; io.branch_retired = 0; io.early_branch_flush = 0;
        do_reset();
        check_state("reset");
        chk("reset_valid_const", {31'b0, io.valid}, 32'd0);

        cyc(1, 0, 32'h100); cyc(1, 0, 32'h200); cyc(1, 0, 32'h300);
        check_state("push3");
        chk("push3_top", io.addr, 32'h300);
        cyc(0, 1, 0); chk("pop1_top", io.addr, 32'h200);
        cyc(0, 1, 0); chk("pop2_top", io.addr, 32'h100);
        cyc(0, 1, 0); chk("pop3_valid", {31'b0, io.valid}, 32'd0);
        check_state("pop3");

        do_reset();
        for (int i = 1; i <= 9; i++) cyc(1, 0, 32'(i * 'h10));
        chk("ovf_count", 32'(dut.count_q), 32'd8);
        chk("ovf_top", io.addr, 32'h90);
        for (int i = 0; i < 7; i++) begin
            cyc(0, 1, 0);
            check_state("ovf_pop");
        end
        chk("ovf_last", io.addr, 32'h20);
        cyc(0, 1, 0);
        chk("ovf_empty", {31'b0, io.valid}, 32'd0);
        cyc(0, 1, 0);
        chk("underflow_idx", 32'(dut.read_index_q), 32'(m_ri));
        check_state("underflow");

        do_reset();
        cyc(1, 0, 32'h100);
        cyc(1, 1, 32'h500);
        chk("swap_top", io.addr, 32'h500);
        chk("swap_count", 32'(dut.count_q), 32'd1);
        cyc(0, 1, 0);
        chk("swap_pop_valid", {31'b0, io.valid}, 32'd0);

        do_reset();
        cyc(1, 0, 32'hA0); cyc(0, 0, 0, 1); cyc(1, 0, 32'hB0); cyc(1, 0, 32'hC0);
        cyc(0, 0, 0, 0, 0, 1);
        check_state("flush");
`ifdef RAS_RECOVERY_EN
        chk("flush_top", io.addr, 32'hA0);
        chk("flush_count", 32'(dut.count_q), 32'd1);
`else
        chk("flush_top", io.addr, 32'hC0);
        chk("flush_count", 32'(dut.count_q), 32'd3);
`endif

        do_reset();
        cyc(1, 0, 32'h11);
        for (int k = 0; k < 8; k++) cyc(1, 0, 32'(32'h20 + k), 1);
        cyc(0, 0, 0, 1, 1);
        check_state("fifo_full");
        cyc(0, 1, 0, 0, 0, 1);
        check_state("fifo_flush");
`ifdef RAS_RECOVERY_EN
        chk("fifo_flush_top", io.addr, 32'h20);
        chk("fifo_flush_count", 32'(dut.count_q), 32'd2);
`else
        chk("fifo_flush_top", io.addr, 32'h26);
        chk("fifo_flush_count", 32'(dut.count_q), 32'd7);
`endif

        do_reset();
        cyc(1, 0, 32'hA0); cyc(0, 0, 0, 1); cyc(1, 0, 32'hB0);
        cyc(0, 0, 0, 0, 0, 1);
`ifdef RAS_RECOVERY_EN
        chk("spec_flush_top", io.addr, 32'hA0);
`else
        chk("spec_flush_top", io.addr, 32'hB0);
`endif

        for (int n = 0; n < 500; n++) begin
            cyc($urandom_range(2) == 0, $urandom_range(2) == 0, $urandom,
                $urandom_range(3) == 0, $urandom_range(3) == 0,
                $urandom_range(15) == 0, $urandom_range(63) != 0);
            check_state("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
